// File: rtl/sweep_pkg.sv
// Shared types and sizes for the truth-table sweep controller and its result store.
package sweep_pkg;

    localparam int unsigned IN_W   = 4;
    localparam int unsigned OUT_W  = 3;
    localparam int unsigned NCODES = 16;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned SCNT_W = 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StDrive   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

endpackage

// File: rtl/result_store.sv
// 16-entry result register file: synchronous write, synchronous clear, registered read.
module result_store
    import sweep_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [IN_W-1:0]  i_waddr,
    input  logic [OUT_W-1:0] i_wdata,
    input  logic [IN_W-1:0]  i_raddr,
    output logic [OUT_W-1:0] o_rdata
);

    logic [OUT_W-1:0] r_mem [NCODES];
    logic [OUT_W-1:0] r_rdata;

    // Read samples the array before this edge's write lands, so a collision returns old data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NCODES); i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a 4-bit code through 0..15, holds each for SETTLE cycles plus a capture cycle,
// and records the fed-back result into a readable truth table.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    output logic [IN_W-1:0]  o_code,
    input  logic [OUT_W-1:0] i_res,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_o2_cnt,
    input  logic [IN_W-1:0]  i_rd_addr,
    output logic [OUT_W-1:0] o_rd_data
);

    localparam logic [SCNT_W-1:0] SettleLast = SCNT_W'(SETTLE - 1);
    localparam logic [IN_W-1:0]   LastCode   = IN_W'(NCODES - 1);

    state_e            r_state;
    state_e            w_state_next;
    logic [SCNT_W-1:0] r_settle;
    logic [IN_W-1:0]   r_code;
    logic [CNT_W-1:0]  r_o2_cnt;
    logic              w_settled;
    logic              w_last_code;
    logic              w_capture;

    assign w_settled   = (r_settle == SettleLast);
    assign w_last_code = (r_code == LastCode);
    // Abort wins over a same-cycle capture.
    assign w_capture   = (r_state == StCapture) && !i_abort;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (i_start) w_state_next = StDrive;
            end
            StDrive: begin
                if (i_abort)        w_state_next = StIdle;
                else if (w_settled) w_state_next = StCapture;
            end
            StCapture: begin
                if (i_abort)          w_state_next = StIdle;
                else if (w_last_code) w_state_next = StDone;
                else                  w_state_next = StDrive;
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_busy = (r_state == StDrive) || (r_state == StCapture);
        o_done = (r_state == StDone);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_settle <= '0;
            r_code   <= '0;
            r_o2_cnt <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_code <= '0;
                    if (i_start) begin
                        r_settle <= '0;
                        r_o2_cnt <= '0;
                    end
                end
                StDrive: begin
                    if (i_abort) begin
                        r_code <= '0;
                    end else if (!w_settled) begin
                        r_settle <= r_settle + SCNT_W'(1);
                    end
                end
                StCapture: begin
                    if (i_abort) begin
                        r_code <= '0;
                    end else begin
                        r_o2_cnt <= r_o2_cnt + CNT_W'(i_res[2]);
                        if (!w_last_code) begin
                            r_code   <= r_code + IN_W'(1);
                            r_settle <= '0;
                        end
                    end
                end
                StDone:  r_code <= '0;
                default: r_code <= '0;
            endcase
        end
    end

    assign o_code   = r_code;
    assign o_o2_cnt = r_o2_cnt;

    result_store u_store (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_capture),
        .i_waddr (r_code),
        .i_wdata (i_res),
        .i_raddr (i_rd_addr),
        .o_rdata (o_rd_data)
    );

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: three sweepers (SETTLE 2, 1, 3) fed by a table-driven stand-in for
// the downstream logic; a plain array model predicts the captured table and o2 count.
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst;
    logic       abort;
    logic [3:0] rd_addr;
    logic [2:0] tbl [16];

    logic       start_a [3];
    logic [3:0] code_a  [3];
    logic [2:0] res_a   [3];
    logic       busy_a  [3];
    logic       done_a  [3];
    logic [4:0] o2_a    [3];
    logic [2:0] rd_a    [3];

    logic [2:0] exp_mem [16];
    int         exp_o2;
    int         checks;
    int         errors;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign res_a[g] = tbl[code_a[g]];
        truth_table_sweeper #(
            .SETTLE ((g == 0) ? 2 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_start   (start_a[g]),
            .i_abort   ((g == 0) ? abort : 1'b0),
            .o_code    (code_a[g]),
            .i_res     (res_a[g]),
            .o_busy    (busy_a[g]),
            .o_done    (done_a[g]),
            .o_o2_cnt  (o2_a[g]),
            .i_rd_addr (rd_addr),
            .o_rd_data (rd_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int settle_of(input int w);
        return (w == 0) ? 2 : ((w == 1) ? 1 : 3);
    endfunction

    // Truth table of the downstream minimization block, repeating every 4 codes.
    function automatic logic [2:0] minim(input int c);
        case (c % 4)
            0:       return 3'b010;
            1:       return 3'b101;
            2:       return 3'b100;
            default: return 3'b011;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_pattern();
        for (int i = 0; i < 16; i++) tbl[i] = minim(i);
    endtask

    task automatic load_random();
        for (int i = 0; i < 16; i++) tbl[i] = 3'($urandom_range(0, 7));
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            tick();
            check($sformatf("rd[%0d]", a), 32'(rd_a[0]), 32'(exp_mem[a]));
        end
    endtask

    // stop_k >= 0: abort (or reset if stop_rst) during the cycle after edge stop_k.
    task automatic run_sweep(input int w, input int stop_k, input bit stop_rst,
                             input int busy_start_k, input bit start_in_done,
                             input int coll_addr);
        int         s;
        int         total;
        int         cap_edge;
        logic [2:0] old_coll;
        s        = settle_of(w);
        total    = 16 * (s + 1);
        cap_edge = coll_addr * (s + 1) + s + 1;
        old_coll = 3'b000;
        if (coll_addr >= 0) begin
            rd_addr  = 4'(coll_addr);
            old_coll = exp_mem[coll_addr];
        end
        start_a[w] = 1'b1;
        tick();
        start_a[w] = 1'b0;
        for (int k = 0; k < total; k++) begin
            check($sformatf("code[%0d]k%0d", w, k), 32'(code_a[w]), 32'(k / (s + 1)));
            check($sformatf("busy[%0d]k%0d", w, k), 32'(busy_a[w]), 32'(1));
            check($sformatf("done[%0d]k%0d", w, k), 32'(done_a[w]), 32'(0));
            if (w == 0 && k == 0) check("o2_clear", 32'(o2_a[0]), 32'(0));
            if (coll_addr >= 0 && k == cap_edge) check("coll_old", 32'(rd_a[0]), 32'(old_coll));
            if (coll_addr >= 0 && k == cap_edge + 1)
                check("coll_new", 32'(rd_a[0]), 32'(tbl[coll_addr]));
            if (k == stop_k) begin
                if (stop_rst) rst = 1'b1;
                else          abort = 1'b1;
                tick();
                rst   = 1'b0;
                abort = 1'b0;
                if (w == 0) begin
                    exp_o2 = 0;
                    for (int c = 0; c < 16; c++) begin
                        if (stop_rst) begin
                            exp_mem[c] = 3'b000;
                        end else if (c * (s + 1) + s + 1 <= k) begin
                            exp_mem[c] = tbl[c];
                            exp_o2 += int'(tbl[c][2]);
                        end
                    end
                    check("stop_o2", 32'(o2_a[0]), 32'(exp_o2));
                    if (stop_rst) check("rst_rd", 32'(rd_a[0]), 32'(0));
                end
                check("stop_code", 32'(code_a[w]), 32'(0));
                for (int j = 0; j < 3; j++) begin
                    check("stop_busy", 32'(busy_a[w]), 32'(0));
                    check("stop_done", 32'(done_a[w]), 32'(0));
                    tick();
                end
                return;
            end
            if (k == busy_start_k) start_a[w] = 1'b1;
            tick();
            start_a[w] = 1'b0;
        end
        check($sformatf("done_pulse[%0d]", w), 32'(done_a[w]), 32'(1));
        check("done_busy", 32'(busy_a[w]), 32'(0));
        check("done_code", 32'(code_a[w]), 32'(15));
        if (w == 0) begin
            exp_o2 = 0;
            for (int c = 0; c < 16; c++) begin
                exp_mem[c] = tbl[c];
                exp_o2 += int'(tbl[c][2]);
            end
            check("full_o2", 32'(o2_a[0]), 32'(exp_o2));
        end
        if (start_in_done) start_a[w] = 1'b1;
        tick();
        start_a[w] = 1'b0;
        check("post_done", 32'(done_a[w]), 32'(0));
        check("post_busy", 32'(busy_a[w]), 32'(0));
        check("post_code", 32'(code_a[w]), 32'(0));
        if (start_in_done) begin
            tick();
            check("done_start_ignored", 32'(busy_a[w]), 32'(0));
        end
    endtask

    initial begin
        int c;
        checks  = 0;
        errors  = 0;
        exp_o2  = 0;
        rst     = 1'b1;
        abort   = 1'b0;
        rd_addr = 4'd0;
        for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 3'b000;
        load_pattern();
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_code", 32'(code_a[0]), 32'(0));
            check("idle_busy", 32'(busy_a[0]), 32'(0));
            check("idle_done", 32'(done_a[0]), 32'(0));
            check("idle_o2", 32'(o2_a[0]), 32'(0));
        end
        read_all();

        // Full sweep against the minimization table, with a start pulse while busy and in DONE.
        run_sweep(0, -1, 1'b0, 10, 1'b1, -1);
        read_all();

        // Random table; entry 7 differs from the pattern so the collision read is visible later.
        load_random();
        tbl[7] = 3'b100;
        run_sweep(0, -1, 1'b0, -1, 1'b0, -1);
        read_all();

        // Abort in the first DRIVE cycle of code 5.
        load_pattern();
        run_sweep(0, 5 * 3, 1'b0, -1, 1'b0, -1);
        read_all();

        // Read/write collision on address 7.
        run_sweep(0, -1, 1'b0, -1, 1'b0, 7);
        read_all();

        // Abort landing on a CAPTURE cycle must suppress that capture.
        load_random();
        c = int'($urandom_range(0, 15));
        run_sweep(0, c * 3 + 2, 1'b0, -1, 1'b0, -1);
        read_all();

        load_random();
        run_sweep(0, int'($urandom_range(0, 47)), 1'b0, -1, 1'b0, -1);
        read_all();

        // Reset mid-sweep at code 9.
        load_pattern();
        run_sweep(0, 9 * 3, 1'b1, -1, 1'b0, -1);
        read_all();

        load_random();
        run_sweep(1, -1, 1'b0, -1, 1'b0, -1);
        run_sweep(2, -1, 1'b0, -1, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
